// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Holds width defaults, FSM encoding and requester indices.
package regfile_write_arbiter_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;

    // Requester indices into the internal ack vector
    localparam int REQ_WB  = 0;
    localparam int REQ_DBG = 1;
    localparam int REQ_LDR = 2;

    localparam logic [2:0] CLR_LAST = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant for the debug host and loader ports.
// Pure combinational; ptr=0 prefers req[0], ptr=1 prefers req[1].
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~ptr | ~req[1]);
    assign gnt[1] = req[1] & ( ptr | ~req[0]);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates three register-file writers (fixed-priority writeback, RR debug/loader)
// and runs an 8-cycle zero-fill; writes reach the file one cycle after ack.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter bit PROTECT_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic [ADDR_W-1:0] dest0,
    input  logic [ADDR_W-1:0] dest1,
    input  logic [ADDR_W-1:0] dest2,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic              ack0,
    output logic              ack1,
    output logic              ack2,
    input  logic              clear_start,
    output logic              busy,
    output logic              stall,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_dest,
    output logic [DATA_W-1:0] write_data
);

    arb_state_t        r_state;
    logic [2:0]        r_clr_cnt;
    logic              r_rr_ptr;
    logic              r_busy;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_dest;
    logic [DATA_W-1:0] r_write_data;

    logic              w_arb_en;
    logic [1:0]        w_rr_gnt;
    logic [2:0]        w_ack;
    logic [ADDR_W-1:0] w_gnt_dest;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_issue;

    // A clear request steals the cycle from every requester
    assign w_arb_en = (r_state == ST_IDLE) & ~clear_start;

    rr_arbiter2 u_rr (
        .req (({req2, req1})),
        .ptr (r_rr_ptr),
        .gnt (w_rr_gnt)
    );

    assign w_ack[REQ_WB]  = w_arb_en & req0;
    assign w_ack[REQ_DBG] = w_arb_en & ~req0 & w_rr_gnt[0];
    assign w_ack[REQ_LDR] = w_arb_en & ~req0 & w_rr_gnt[1];

    always_comb begin
        w_gnt_dest = dest0;
        w_gnt_data = data0;
        if (w_ack[REQ_DBG]) begin
            w_gnt_dest = dest1;
            w_gnt_data = data1;
        end else if (w_ack[REQ_LDR]) begin
            w_gnt_dest = dest2;
            w_gnt_data = data2;
        end
    end

    // r0 writes are accepted so the requester moves on, but never reach the file
    assign w_issue = (|w_ack) & ~(PROTECT_R0 && (w_gnt_dest == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_clr_cnt    <= '0;
            r_rr_ptr     <= 1'b0;
            r_busy       <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_dest <= '0;
            r_write_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_start) begin
                        r_state      <= ST_CLEAR;
                        r_clr_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_reg_write  <= 1'b1;
                        r_write_dest <= '0;
                        r_write_data <= '0;
                    end else begin
                        r_reg_write <= w_issue;
                        if (w_issue) begin
                            r_write_dest <= w_gnt_dest;
                            r_write_data <= w_gnt_data;
                        end
                        if (w_ack[REQ_DBG]) begin
                            r_rr_ptr <= 1'b1;
                        end else if (w_ack[REQ_LDR]) begin
                            r_rr_ptr <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state     <= ST_IDLE;
                        r_clr_cnt   <= '0;
                        r_busy      <= 1'b0;
                        r_reg_write <= 1'b0;
                    end else begin
                        r_clr_cnt    <= r_clr_cnt + 3'd1;
                        r_reg_write  <= 1'b1;
                        r_write_dest <= ADDR_W'(r_clr_cnt + 3'd1);
                        r_write_data <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0       = w_ack[REQ_WB];
    assign ack1       = w_ack[REQ_DBG];
    assign ack2       = w_ack[REQ_LDR];
    assign stall      = req0 & ~w_ack[REQ_WB];
    assign busy       = r_busy;
    assign reg_write  = r_reg_write;
    assign write_dest = r_write_dest;
    assign write_data = r_write_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, req2;
    logic [2:0]  dest0, dest1, dest2;
    logic [15:0] data0, data1, data2;
    logic        ack0, ack1, ack2;
    logic        clear_start;
    logic        busy, stall;
    logic        reg_write;
    logic [2:0]  write_dest;
    logic [15:0] write_data;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(
        .DATA_W     (16),
        .ADDR_W     (3),
        .PROTECT_R0 (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .req2        (req2),
        .dest0       (dest0),
        .dest1       (dest1),
        .dest2       (dest2),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .ack0        (ack0),
        .ack1        (ack1),
        .ack2        (ack2),
        .clear_start (clear_start),
        .busy        (busy),
        .stall       (stall),
        .reg_write   (reg_write),
        .write_dest  (write_dest),
        .write_data  (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 0; req1 = 0; req2 = 0;
        dest0 = 0; dest1 = 0; dest2 = 0;
        data0 = 0; data1 = 0; data2 = 0;
        clear_start = 0;
        #12;
        if ({reg_write, busy, ack0, ack1, ack2, stall} !== 6'b0) begin
            $display("FAIL reset_flags got=%b exp=000000", {reg_write, busy, ack0, ack1, ack2, stall});
            bad++;
        end
        total++;
        if (write_dest !== 3'd0 || write_data !== 16'h0) begin
            $display("FAIL reset_write got=%0d/%h exp=0/0000", write_dest, write_data);
            bad++;
        end
        total++;
        #1 rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_priority();
        req0 = 1; dest0 = 3'd3; data0 = 16'h1234;
        req1 = 1; dest1 = 3'd4; data1 = 16'hAAAA;
        #1;
        if ({ack0, ack1, ack2, stall} !== 4'b1000) begin
            $display("FAIL prio_acks got=%b exp=1000", {ack0, ack1, ack2, stall});
            bad++;
        end
        total++;
        next_cycle();
        req0 = 0; req1 = 0;
        if (reg_write !== 1'b1 || write_dest !== 3'd3 || write_data !== 16'h1234) begin
            $display("FAIL prio_write got=%b/%0d/%h exp=1/3/1234", reg_write, write_dest, write_data);
            bad++;
        end
        total++;
        next_cycle();
        if (reg_write !== 1'b0 || write_dest !== 3'd3 || write_data !== 16'h1234) begin
            $display("FAIL idle_hold got=%b/%0d/%h exp=0/3/1234", reg_write, write_dest, write_data);
            bad++;
        end
        total++;
    endtask

    // Pointer must move only on port-1/2 grants, not on a port-0 grant
    task automatic test_ptr_hold();
        req1 = 1; dest1 = 3'd6; data1 = 16'h0606;
        #1;
        if ({ack0, ack1, ack2} !== 3'b010) begin
            $display("FAIL ptr_a got=%b exp=010", {ack0, ack1, ack2});
            bad++;
        end
        total++;
        next_cycle();
        req0 = 1; req2 = 1; dest0 = 3'd5; data0 = 16'h0505; dest2 = 3'd7; data2 = 16'h0707;
        #1;
        if ({ack0, ack1, ack2} !== 3'b100) begin
            $display("FAIL ptr_b got=%b exp=100", {ack0, ack1, ack2});
            bad++;
        end
        total++;
        next_cycle();
        req0 = 0;
        #1;
        if ({ack0, ack1, ack2} !== 3'b001) begin
            $display("FAIL ptr_c got=%b exp=001", {ack0, ack1, ack2});
            bad++;
        end
        total++;
        next_cycle();
        req1 = 0; req2 = 0;
        if (reg_write !== 1'b1 || write_dest !== 3'd7 || write_data !== 16'h0707) begin
            $display("FAIL ptr_write got=%b/%0d/%h exp=1/7/0707", reg_write, write_dest, write_data);
            bad++;
        end
        total++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ack;
        exp_ack = 4'b1010;
        req1 = 1; dest1 = 3'd1; data1 = 16'h1111;
        req2 = 1; dest2 = 3'd2; data2 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ack1 !== exp_ack[3-i] || ack2 !== ~exp_ack[3-i] || ack0 !== 1'b0) begin
                $display("FAIL rr_ack%0d got=%b%b exp=%b%b", i, ack1, ack2, exp_ack[3-i], ~exp_ack[3-i]);
                bad++;
            end
            total++;
            next_cycle();
            if (reg_write !== 1'b1 ||
                write_dest !== (exp_ack[3-i] ? 3'd1 : 3'd2) ||
                write_data !== (exp_ack[3-i] ? 16'h1111 : 16'h2222)) begin
                $display("FAIL rr_write%0d got=%b/%0d/%h", i, reg_write, write_dest, write_data);
                bad++;
            end
            total++;
        end
        req1 = 0; req2 = 0;
        next_cycle();
    endtask

    task automatic test_protect_r0();
        req2 = 1; dest2 = 3'd0; data2 = 16'hFFFF;
        #1;
        if ({ack0, ack1, ack2} !== 3'b001) begin
            $display("FAIL r0_ack got=%b exp=001", {ack0, ack1, ack2});
            bad++;
        end
        total++;
        next_cycle();
        req2 = 0;
        if (reg_write !== 1'b0) begin
            $display("FAIL r0_write got=%b exp=0", reg_write);
            bad++;
        end
        total++;
        next_cycle();
    endtask

    task automatic test_clear();
        int stall_cnt;
        int busy_cnt;
        stall_cnt = 0;
        busy_cnt  = 0;
        req0 = 1; dest0 = 3'd5; data0 = 16'h5555;
        clear_start = 1;
        #1;
        if (ack0 !== 1'b0 || stall !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL clr_entry got=ack%b stall%b busy%b exp=ack0 stall1 busy0", ack0, stall, busy);
            bad++;
        end
        total++;
        if (stall === 1'b1) stall_cnt++;
        next_cycle();
        clear_start = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) clear_start = 1;
            #1;
            if (busy !== 1'b1 || reg_write !== 1'b1 || write_dest !== k[2:0] ||
                write_data !== 16'h0 || ack0 !== 1'b0) begin
                $display("FAIL clr_cycle%0d got=busy%b wr%b dest%0d data%h ack%b",
                         k, busy, reg_write, write_dest, write_data, ack0);
                bad++;
            end
            total++;
            if (stall === 1'b1) stall_cnt++;
            if (busy === 1'b1) busy_cnt++;
            next_cycle();
            clear_start = 0;
        end
        if (busy !== 1'b0 || reg_write !== 1'b0 || ack0 !== 1'b1 || stall !== 1'b0) begin
            $display("FAIL clr_exit got=busy%b wr%b ack%b stall%b exp=busy0 wr0 ack1 stall0",
                     busy, reg_write, ack0, stall);
            bad++;
        end
        total++;
        if (stall_cnt != 9 || busy_cnt != 8) begin
            $display("FAIL clr_counts got=stall%0d busy%0d exp=stall9 busy8", stall_cnt, busy_cnt);
            bad++;
        end
        total++;
        next_cycle();
        req0 = 0;
        if (reg_write !== 1'b1 || write_dest !== 3'd5 || write_data !== 16'h5555) begin
            $display("FAIL clr_after got=%b/%0d/%h exp=1/5/5555", reg_write, write_dest, write_data);
            bad++;
        end
        total++;
        next_cycle();
    endtask

    task automatic test_reset_during_clear();
        clear_start = 1;
        next_cycle();
        clear_start = 0;
        for (int k = 0; k < 3; k++) begin
            if (write_dest !== k[2:0] || busy !== 1'b1) begin
                $display("FAIL abort_pre%0d got=dest%0d busy%b exp=dest%0d busy1", k, write_dest, busy, k);
                bad++;
            end
            total++;
            next_cycle();
        end
        rst = 1'b1;
        #1;
        if (busy !== 1'b0 || reg_write !== 1'b0 || write_dest !== 3'd0) begin
            $display("FAIL abort_now got=busy%b wr%b dest%0d exp=busy0 wr0 dest0", busy, reg_write, write_dest);
            bad++;
        end
        total++;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            if (reg_write !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL abort_post%0d got=wr%b busy%b exp=wr0 busy0", k, reg_write, busy);
                bad++;
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_ptr_hold();
        test_back_to_back();
        test_protect_r0();
        test_clear();
        test_reset_during_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
